seq_gf_mult_red_unit: RTL and testbench

//   Multi-cycle, digit-serial arithmetic unit: integer/carry-less add, multiply, square,
//   GF(2^m) reduction, and fused multiply-then-reduce.

---
 rtl/gf_unit_pkg.sv | 34 +++
 rtl/gf_digit_step.sv | 52 +++++
 rtl/seq_gf_mult_red_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_gf_mult_red_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_unit_pkg.sv
// Shared types for the sequential GF(2^m) multiply / reduce unit.
// Contents: opcode and FSM-state enums, default sizing, step-count and opcode helpers.
// No ports; imported by seq_gf_mult_red_unit and gf_digit_step.
package gf_unit_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_BITS_PER_CYCLE = 1;

   typedef enum logic [2:0] {
      OP_ADD      = 3'd0,
      OP_MULT     = 3'd1,
      OP_SQR      = 3'd2,
      OP_RED      = 3'd3,
      OP_MULT_RED = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_RED  = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

   // Number of digit steps needed to walk a W-bit operand D bits at a time.
   function automatic int gf_steps(input int w, input int d);
      return w / d;
   endfunction

   // Opcodes 5..7 are reserved and reported through err.
   function automatic logic op_is_legal(input logic [2:0] op);
      return (op <= 3'(OP_MULT_RED));
   endfunction

endpackage

// File: rtl/gf_digit_step.sv
// One D-bit digit step of the sequential unit, purely combinational.
// Multiply mode: adds/XORs up to D shifted partial products; reduce mode: up to D polynomial XORs.
// Ports: red_mode_i/carry_i select the operation, acc_i/acc_o the 2W accumulator, idx_i the step index.
module gf_digit_step
   import gf_unit_pkg::*;
#(
   parameter int W  = DEF_DATA_WIDTH,
   parameter int D  = DEF_BITS_PER_CYCLE,
   parameter int CW = 6
) (
   input  logic             red_mode_i,
   input  logic             carry_i,
   input  logic [2*W-1:0]   acc_i,
   input  logic [W-1:0]     mcand_i,
   input  logic [W-1:0]     mplier_i,
   input  logic [W:0]       poly_i,
   input  logic [CW-1:0]    idx_i,
   output logic [2*W-1:0]   acc_o
);

   logic [2*W-1:0] mul_acc;
   logic [2*W-1:0] red_acc;
   logic [2*W-1:0] pp;
   logic [2*W-1:0] poly_ext;
   logic [2*W-1:0] rem_sh;
   logic [W-1:0]   mp_sh;

   always_comb begin
      mul_acc  = acc_i;
      red_acc  = acc_i;
      pp       = '0;
      rem_sh   = '0;
      mp_sh    = '0;
      poly_ext = {{(W-1){1'b0}}, poly_i};
      for (int j = 0; j < D; j++) begin
         // Multiplier bit idx*D+j, LSB first; partial product is the multiplicand at that weight.
         mp_sh = mplier_i >> (int'(idx_i) * D + j);
         pp    = {{W{1'b0}}, mcand_i} << (int'(idx_i) * D + j);
         if (mp_sh[0]) begin
            mul_acc = carry_i ? (mul_acc + pp) : (mul_acc ^ pp);
         end
         // Remainder bit p = 2W-1-idx*D-j, MSB first. The running value is used so a
         // lower bit sees the XORs already applied by higher bits in the same step.
         rem_sh = red_acc >> (2*W - 1 - int'(idx_i) * D - j);
         if (rem_sh[0]) begin
            red_acc = red_acc ^ (poly_ext << (W - 1 - int'(idx_i) * D - j));
         end
      end
      acc_o = red_mode_i ? red_acc : mul_acc;
   end

endmodule

// File: rtl/seq_gf_mult_red_unit.sv
// Digit-serial add / multiply / square / GF(2^m) reduce / multiply-then-reduce engine.
// Latency: ADD 1, MULT/SQR/RED W/D, MULT_RED 2W/D, error 1 edge; done pulses one cycle.
// Handshake: start is taken only when idle (including the done cycle); start while busy is dropped.
// Ports: clk, rst (async active-high), start/op/carry_option/polyn_red_in/reduc_in/a/b in;
//        busy, done, err, out (W), mult_out (2W) out, all registered.
module seq_gf_mult_red_unit
   import gf_unit_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [2:0]                op,
   input  logic                      carry_option,
   input  logic [DATA_WIDTH:0]       polyn_red_in,
   input  logic [2*DATA_WIDTH-1:0]   reduc_in,
   input  logic [DATA_WIDTH-1:0]     a,
   input  logic [DATA_WIDTH-1:0]     b,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [DATA_WIDTH-1:0]     out,
   output logic [2*DATA_WIDTH-1:0]   mult_out
);

   localparam int W     = DATA_WIDTH;
   localparam int D     = BITS_PER_CYCLE;
   localparam int STEPS = gf_steps(W, D);
   localparam int CW    = $clog2(STEPS) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(STEPS - 1);

   if ((DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("BITS_PER_CYCLE must divide DATA_WIDTH");
   end

   // Latched request
   state_e          state_q;
   logic [2:0]      op_q;
   logic            carry_q;
   logic            err_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;      // multiplier: b, or a for SQR
   logic [W:0]      poly_q;
   logic [2*W-1:0]  hold_q;   // value reported on mult_out for RED / MULT_RED
   logic [2*W-1:0]  acc_q;    // product accumulator, then reduction remainder
   logic [CW-1:0]   idx_q;

   // Registered outputs
   logic            busy_q;
   logic            done_q;
   logic            err_out_q;
   logic [W-1:0]    out_q;
   logic [2*W-1:0]  mult_q;

   // Shared step datapath
   logic            st_red;
   logic            st_carry;
   logic [2*W-1:0]  st_acc;
   logic [W-1:0]    st_mcand;
   logic [W-1:0]    st_mplier;
   logic [W:0]      st_poly;
   logic [CW-1:0]   st_idx;
   logic [2*W-1:0]  acc_d;

   logic            needs_poly;
   logic            cfg_err;
   logic [W:0]      add_sum;

   assign needs_poly = (op == OP_RED) || (op == OP_MULT_RED);
   assign cfg_err    = !op_is_legal(op) || (needs_poly && !polyn_red_in[W]);
   assign add_sum    = {1'b0, a_q} + {1'b0, b_q};

   // Step 0 runs on the accepting edge straight from the ports, so the remaining steps fit
   // the W/D latency with the FIN cycle included. Afterwards the latched copies feed it.
   always_comb begin
      st_red    = 1'b0;
      st_carry  = 1'b0;
      st_acc    = '0;
      st_mcand  = '0;
      st_mplier = '0;
      st_poly   = '0;
      st_idx    = '0;
      if (state_q == ST_IDLE) begin
         st_red    = (op == OP_RED);
         st_carry  = carry_option && (op != OP_MULT_RED);
         st_acc    = (op == OP_RED) ? reduc_in : '0;
         st_mcand  = a;
         st_mplier = (op == OP_SQR) ? a : b;
         st_poly   = polyn_red_in;
      end else begin
         st_red    = (state_q == ST_RED);
         st_carry  = carry_q;
         st_acc    = acc_q;
         st_mcand  = a_q;
         st_mplier = b_q;
         st_poly   = poly_q;
         st_idx    = idx_q;
      end
   end

   gf_digit_step #(
      .W  (W),
      .D  (D),
      .CW (CW)
   ) u_step (
      .red_mode_i (st_red),
      .carry_i    (st_carry),
      .acc_i      (st_acc),
      .mcand_i    (st_mcand),
      .mplier_i   (st_mplier),
      .poly_i     (st_poly),
      .idx_i      (st_idx),
      .acc_o      (acc_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         carry_q   <= 1'b0;
         err_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         poly_q    <= '0;
         hold_q    <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_out_q <= 1'b0;
         out_q     <= '0;
         mult_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  busy_q  <= 1'b1;
                  op_q    <= op;
                  a_q     <= a;
                  b_q     <= (op == OP_SQR) ? a : b;
                  carry_q <= carry_option && (op != OP_MULT_RED);
                  poly_q  <= polyn_red_in;
                  hold_q  <= reduc_in;
                  err_q   <= cfg_err;
                  acc_q   <= acc_d;
                  idx_q   <= CW'(1);
                  if (cfg_err || (op == OP_ADD)) begin
                     state_q <= ST_FIN;
                  end else if (op == OP_RED) begin
                     state_q <= (STEPS == 1) ? ST_FIN : ST_RED;
                  end else if (STEPS > 1) begin
                     state_q <= ST_MUL;
                  end else if (op == OP_MULT_RED) begin
                     // Single-step product is already complete: reduce it next.
                     state_q <= ST_RED;
                     idx_q   <= '0;
                     hold_q  <= acc_d;
                  end else begin
                     state_q <= ST_FIN;
                  end
               end
            end
            ST_MUL: begin
               acc_q <= acc_d;
               if (idx_q == LAST_IDX) begin
                  if (op_q == OP_MULT_RED) begin
                     state_q <= ST_RED;
                     idx_q   <= '0;
                     hold_q  <= acc_d;
                  end else begin
                     state_q <= ST_FIN;
                  end
               end else begin
                  idx_q <= idx_q + CW'(1);
               end
            end
            ST_RED: begin
               acc_q <= acc_d;
               if (idx_q == LAST_IDX) begin
                  state_q <= ST_FIN;
               end else begin
                  idx_q <= idx_q + CW'(1);
               end
            end
            ST_FIN: begin
               state_q   <= ST_IDLE;
               busy_q    <= 1'b0;
               done_q    <= 1'b1;
               err_out_q <= err_q;
               if (err_q) begin
                  out_q  <= '0;
                  mult_q <= '0;
               end else begin
                  case (op_q)
                     OP_ADD: begin
                        if (carry_q) begin
                           out_q  <= add_sum[W-1:0];
                           mult_q <= {{(W-1){1'b0}}, add_sum};
                        end else begin
                           out_q  <= a_q ^ b_q;
                           mult_q <= {{W{1'b0}}, a_q ^ b_q};
                        end
                     end
                     OP_RED, OP_MULT_RED: begin
                        out_q  <= acc_q[W-1:0];
                        mult_q <= hold_q;
                     end
                     default: begin
                        out_q  <= acc_q[W-1:0];
                        mult_q <= acc_q;
                     end
                  endcase
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_out_q;
   assign out      = out_q;
   assign mult_out = mult_q;

endmodule

// File: tb/tb_seq_gf_mult_red_unit.sv
`timescale 1ns/1ps
module tb_seq_gf_mult_red_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start_w;
   logic [2:0]  op_r;
   logic        cy_r;
   logic [8:0]  poly_r;
   logic [15:0] red_r;
   logic [7:0]  a_r;
   logic [7:0]  b_r;

   logic        busy_w [2];
   logic        done_w [2];
   logic        err_w  [2];
   logic [7:0]  out_w  [2];
   logic [15:0] mult_w [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Index 0: one bit per cycle, index 1: two bits per cycle.
   seq_gf_mult_red_unit #(.DATA_WIDTH(8), .BITS_PER_CYCLE(1)) u_d1 (
      .clk(clk), .rst(rst), .start(start_w[0]), .op(op_r), .carry_option(cy_r),
      .polyn_red_in(poly_r), .reduc_in(red_r), .a(a_r), .b(b_r),
      .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .out(out_w[0]), .mult_out(mult_w[0]));

   seq_gf_mult_red_unit #(.DATA_WIDTH(8), .BITS_PER_CYCLE(2)) u_d2 (
      .clk(clk), .rst(rst), .start(start_w[1]), .op(op_r), .carry_option(cy_r),
      .polyn_red_in(poly_r), .reduc_in(red_r), .a(a_r), .b(b_r),
      .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .out(out_w[1]), .mult_out(mult_w[1]));

   // ---------------- reference model ----------------
   function automatic logic [15:0] ref_clmul(input logic [7:0] x, input logic [7:0] y);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) if (y[i]) r ^= (16'(x) << i);
      return r;
   endfunction

   function automatic int ref_deg(input logic [15:0] v);
      for (int i = 15; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   // Polynomial long division: cancel the leading term until degree < 8.
   function automatic logic [7:0] ref_mod(input logic [15:0] v, input logic [8:0] p);
      logic [15:0] r;
      r = v;
      for (int n = 0; n < 16 && ref_deg(r) >= 8; n++) r ^= (16'(p) << (ref_deg(r) - 8));
      return r[7:0];
   endfunction

   function automatic int lat_of(input logic [2:0] op, input logic e, input int d);
      if (e || op == 3'd0) return 1;
      if (op == 3'd4) return 16 / d;
      return 8 / d;
   endfunction

   task automatic ref_model(input logic [2:0] op, input logic cy, input logic [7:0] a, input logic [7:0] b,
                            input logic [8:0] p, input logic [15:0] r,
                            output logic [7:0] eo, output logic [15:0] em, output logic ee);
      logic [8:0] s9;
      eo = '0; em = '0; ee = 1'b0;
      if (op > 3'd4 || ((op == 3'd3 || op == 3'd4) && !p[8])) begin
         ee = 1'b1;
      end else begin
         case (op)
            3'd0: begin
               if (cy) begin s9 = 9'(a) + 9'(b); em = {7'd0, s9}; end
               else em = {8'd0, a ^ b};
               eo = em[7:0];
            end
            3'd1: begin em = cy ? (16'(a) * 16'(b)) : ref_clmul(a, b); eo = em[7:0]; end
            3'd2: begin em = cy ? (16'(a) * 16'(a)) : ref_clmul(a, a); eo = em[7:0]; end
            3'd3: begin em = r; eo = ref_mod(r, p); end
            default: begin em = ref_clmul(a, b); eo = ref_mod(em, p); end
         endcase
      end
   endtask

   // ---------------- single-operation scenario ----------------
   task automatic run_one(input string name, input logic [2:0] op, input logic cy,
                          input logic [7:0] a, input logic [7:0] b, input logic [8:0] p,
                          input logic [15:0] r, input logic [7:0] eo, input logic [15:0] em,
                          input logic ee);
      int lat[2]; int seen[2]; int pulses[2]; bit busy_ok[2]; bit hold_ok[2];
      logic [7:0] go[2]; logic [7:0] po[2]; logic [15:0] gm[2]; logic [15:0] pm[2]; logic ge[2];
      for (int i = 0; i < 2; i++) begin
         lat[i] = lat_of(op, ee, i + 1); seen[i] = 0; pulses[i] = 0;
         busy_ok[i] = 1'b1; hold_ok[i] = 1'b1;
         po[i] = out_w[i]; pm[i] = mult_w[i]; go[i] = '0; gm[i] = '0; ge[i] = 1'b0;
      end
      @(negedge clk);
      op_r = op; cy_r = cy; a_r = a; b_r = b; poly_r = p; red_r = r; start_w = 2'b11;
      @(posedge clk); #1;
      start_w = 2'b00;
      op_r = 3'($urandom); cy_r = 1'($urandom); a_r = 8'($urandom); b_r = 8'($urandom);
      poly_r = 9'($urandom); red_r = 16'($urandom);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (busy_w[i] !== (c < lat[i])) busy_ok[i] = 1'b0;
            if (done_w[i] === 1'b1) begin
               pulses[i]++;
               if (seen[i] == 0) begin seen[i] = c; go[i] = out_w[i]; gm[i] = mult_w[i]; ge[i] = err_w[i]; end
            end else if (seen[i] == 0 && (out_w[i] !== po[i] || mult_w[i] !== pm[i])) begin
               hold_ok[i] = 1'b0;
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         checks++; if (seen[i] !== lat[i])
            begin errors++; $display("FAIL %s D=%0d latency: got %0d want %0d", name, i + 1, seen[i], lat[i]); end
         checks++; if (pulses[i] !== 1)
            begin errors++; $display("FAIL %s D=%0d done pulses: got %0d want 1", name, i + 1, pulses[i]); end
         checks++; if (go[i] !== eo)
            begin errors++; $display("FAIL %s D=%0d out: got %h want %h", name, i + 1, go[i], eo); end
         checks++; if (gm[i] !== em)
            begin errors++; $display("FAIL %s D=%0d mult_out: got %h want %h", name, i + 1, gm[i], em); end
         checks++; if (ge[i] !== ee)
            begin errors++; $display("FAIL %s D=%0d err: got %b want %b", name, i + 1, ge[i], ee); end
         checks++; if (busy_ok[i] !== 1'b1)
            begin errors++; $display("FAIL %s D=%0d busy profile: got bad want high until done", name, i + 1); end
         checks++; if (hold_ok[i] !== 1'b1)
            begin errors++; $display("FAIL %s D=%0d output hold: got change before done want stable", name, i + 1); end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; start_w = 2'b00; op_r = '0; cy_r = 1'b0; a_r = '0; b_r = '0;
      poly_r = 9'h11B; red_r = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({busy_w[i], done_w[i], err_w[i], out_w[i], mult_w[i]} !== 27'd0) begin
            errors++;
            $display("FAIL reset D=%0d outputs: got busy=%b done=%b err=%b out=%h mult=%h want all 0",
                     i + 1, busy_w[i], done_w[i], err_w[i], out_w[i], mult_w[i]);
         end
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_add();
      run_one("add_carry", 3'd0, 1'b1, 8'hFF, 8'h01, 9'h11B, 16'h0, 8'h00, 16'h0100, 1'b0);
      run_one("add_xor",   3'd0, 1'b0, 8'hFF, 8'h01, 9'h11B, 16'h0, 8'hFE, 16'h00FE, 1'b0);
   endtask

   task automatic test_mult();
      run_one("mult_cl", 3'd1, 1'b0, 8'h57, 8'h83, 9'h11B, 16'h0, 8'h79, 16'h2B79, 1'b0);
      run_one("mult_cy", 3'd1, 1'b1, 8'h57, 8'h83, 9'h11B, 16'h0, 8'h85, 16'h2C85, 1'b0);
   endtask

   task automatic test_sqr_red();
      run_one("sqr", 3'd2, 1'b0, 8'h57, 8'h3C, 9'h11B, 16'h0,    8'h15, 16'h1115, 1'b0);
      run_one("red", 3'd3, 1'b1, 8'h00, 8'h00, 9'h11B, 16'h2B79, 8'hC1, 16'h2B79, 1'b0);
   endtask

   task automatic test_mult_red();
      run_one("mult_red", 3'd4, 1'b1, 8'h57, 8'h83, 9'h11B, 16'h0, 8'hC1, 16'h2B79, 1'b0);
   endtask

   task automatic test_err();
      run_one("red_badpoly",  3'd3, 1'b0, 8'h57, 8'h83, 9'h01B, 16'h2B79, 8'h00, 16'h0000, 1'b1);
      run_one("op7",          3'd7, 1'b1, 8'h57, 8'h83, 9'h11B, 16'h2B79, 8'h00, 16'h0000, 1'b1);
      run_one("mred_badpoly", 3'd4, 1'b0, 8'h57, 8'h83, 9'h0FF, 16'h0000, 8'h00, 16'h0000, 1'b1);
   endtask

   task automatic test_boundaries();
      run_one("mult_a0",   3'd1, 1'b1, 8'h00, 8'h5A, 9'h11B, 16'h0,    8'h00, 16'h0000, 1'b0);
      run_one("mult_b0",   3'd1, 1'b0, 8'hA5, 8'h00, 9'h11B, 16'h0,    8'h00, 16'h0000, 1'b0);
      run_one("mult_ones", 3'd1, 1'b1, 8'hFF, 8'hFF, 9'h11B, 16'h0,    8'h01, 16'hFE01, 1'b0);
      run_one("red_low",   3'd3, 1'b0, 8'h00, 8'h00, 9'h11B, 16'h00A5, 8'hA5, 16'h00A5, 1'b0);
   endtask

   // start held high throughout: ignored while busy, taken again in the done cycle.
   task automatic test_back_to_back();
      int nd[2]; int t[2][2]; logic [7:0] o[2][2]; logic [15:0] m[2][2]; bit pend[2];
      int l1; int l2;
      for (int i = 0; i < 2; i++) begin
         nd[i] = 0; pend[i] = 1'b0;
         for (int k = 0; k < 2; k++) begin t[i][k] = 0; o[i][k] = '0; m[i][k] = '0; end
      end
      @(negedge clk);
      op_r = 3'd4; cy_r = 1'b1; a_r = 8'h57; b_r = 8'h83; poly_r = 9'h11B; red_r = '0; start_w = 2'b11;
      @(posedge clk); #1;
      op_r = 3'd1; cy_r = 1'b1; a_r = 8'hFF; b_r = 8'hFF;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (pend[i]) begin start_w[i] = 1'b0; pend[i] = 1'b0; end
            if (done_w[i] === 1'b1) begin
               if (nd[i] < 2) begin t[i][nd[i]] = c; o[i][nd[i]] = out_w[i]; m[i][nd[i]] = mult_w[i]; end
               nd[i]++;
               if (nd[i] == 1) pend[i] = 1'b1;
            end
         end
      end
      start_w = 2'b00;
      for (int i = 0; i < 2; i++) begin
         l1 = lat_of(3'd4, 1'b0, i + 1);
         l2 = lat_of(3'd1, 1'b0, i + 1);
         checks++; if (nd[i] !== 2)
            begin errors++; $display("FAIL b2b D=%0d done count: got %0d want 2", i + 1, nd[i]); end
         checks++; if (t[i][0] !== l1)
            begin errors++; $display("FAIL b2b D=%0d first done: got %0d want %0d", i + 1, t[i][0], l1); end
         checks++; if (t[i][1] !== l1 + 1 + l2)
            begin errors++; $display("FAIL b2b D=%0d second done: got %0d want %0d", i + 1, t[i][1], l1 + 1 + l2); end
         checks++; if (o[i][0] !== 8'hC1)
            begin errors++; $display("FAIL b2b D=%0d out1: got %h want c1", i + 1, o[i][0]); end
         checks++; if (m[i][0] !== 16'h2B79)
            begin errors++; $display("FAIL b2b D=%0d mult1: got %h want 2b79", i + 1, m[i][0]); end
         checks++; if (o[i][1] !== 8'h01)
            begin errors++; $display("FAIL b2b D=%0d out2: got %h want 01", i + 1, o[i][1]); end
         checks++; if (m[i][1] !== 16'hFE01)
            begin errors++; $display("FAIL b2b D=%0d mult2: got %h want fe01", i + 1, m[i][1]); end
      end
   endtask

   task automatic test_reset_mid();
      int pulses[2]; bit zero_ok[2];
      for (int i = 0; i < 2; i++) begin pulses[i] = 0; zero_ok[i] = 1'b1; end
      @(negedge clk);
      op_r = 3'd1; cy_r = 1'b1; a_r = 8'h57; b_r = 8'h83; poly_r = 9'h11B; start_w = 2'b11;
      @(posedge clk); #1;
      start_w = 2'b00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (done_w[i] === 1'b1) pulses[i]++;
            if ({busy_w[i], err_w[i], out_w[i], mult_w[i]} !== 26'd0) zero_ok[i] = 1'b0;
         end
      end
      for (int i = 0; i < 2; i++) begin
         checks++; if (pulses[i] !== 0)
            begin errors++; $display("FAIL rst_mid D=%0d done pulses: got %0d want 0", i + 1, pulses[i]); end
         checks++; if (zero_ok[i] !== 1'b1)
            begin errors++; $display("FAIL rst_mid D=%0d outputs: got nonzero want 0", i + 1); end
      end
      run_one("after_rst", 3'd1, 1'b1, 8'h57, 8'h83, 9'h11B, 16'h0, 8'h85, 16'h2C85, 1'b0);
   endtask

   task automatic test_random();
      logic [2:0] op; logic cy; logic [7:0] a; logic [7:0] b; logic [8:0] p; logic [15:0] r;
      logic [7:0] eo; logic [15:0] em; logic ee; int k;
      for (int n = 0; n < 24; n++) begin
         k  = int'($urandom_range(0, 9));
         op = (k < 9) ? 3'(k % 5) : 3'($urandom_range(5, 7));
         cy = 1'($urandom);
         a  = 8'($urandom); b = 8'($urandom); r = 16'($urandom);
         p  = {1'b1, 8'($urandom)};
         if ($urandom_range(0, 3) == 0) p = 9'h11B;
         if ($urandom_range(0, 7) == 0) p[8] = 1'b0;
         ref_model(op, cy, a, b, p, r, eo, em, ee);
         run_one("random", op, cy, a, b, p, r, eo, em, ee);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mult();
      test_sqr_red();
      test_mult_red();
      test_err();
      test_boundaries();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
